// File: rtl/line_buffer.sv
// ----------------------------------------------------------------------------
// line_buffer
//
// Ping-pong line buffer between the layer renderer and the video output.
// The renderer fills the back bank with line N+1 while the display reads
// line N from the front bank. start_of_line swaps the banks, and
// start_of_screen forces bank0 to be the back bank. When CLEAR_ON_READ is
// set, each front-bank entry that is read is zeroed one cycle later, so
// every line starts out transparent.
//
// Parameters:
//   LINE_WIDTH     number of valid pixel slots per line (<= 1024)
//   CLEAR_ON_READ  1: zero each entry on the cycle after it is read
//
// Ports:
//   clk              system clock
//   rst              synchronous active-high reset (control state only)
//   start_of_line    one-cycle pulse, swaps back/front banks
//   start_of_screen  one-cycle pulse, forces bank0 to be the back bank
//   linebuf_wridx    renderer write index (out-of-range writes dropped)
//   linebuf_wrdata   renderer colour index
//   linebuf_wren     renderer write enable
//   rd_idx           display read index
//   rd_en            display read request
//   rd_data          colour index, one cycle after rd_en (0 if out of range)
//   rd_valid         rd_data carries a read result this cycle
// ----------------------------------------------------------------------------
module line_buffer #(
  parameter int LINE_WIDTH    = 640,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_of_line,
  input  logic       start_of_screen,
  input  logic [9:0] linebuf_wridx,
  input  logic [7:0] linebuf_wrdata,
  input  logic       linebuf_wren,
  input  logic [9:0] rd_idx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  // Widened so that LINE_WIDTH = 1024 still compares correctly.
  localparam logic [10:0] LINE_WIDTH_C = 11'(LINE_WIDTH);

  logic [7:0] bank0_mem_r [LINE_WIDTH];
  logic [7:0] bank1_mem_r [LINE_WIDTH];

  logic       wr_bank_r;     // back bank; the front bank is its complement
  logic       clr_pend_r;
  logic       clr_bank_r;
  logic [9:0] clr_idx_r;
  logic [7:0] rd_data_r;
  logic       rd_valid_r;

  logic       wr_in_range_s;
  logic       rd_in_range_s;
  logic       clr_fire_s;
  logic [7:0] rd_word_s;
  logic       bank0_we_s;
  logic [9:0] bank0_widx_s;
  logic [7:0] bank0_wdata_s;
  logic       bank1_we_s;
  logic [9:0] bank1_widx_s;
  logic [7:0] bank1_wdata_s;

  // Range qualification of the renderer and display indices
  always_comb begin
    wr_in_range_s = linebuf_wren && ({1'b0, linebuf_wridx} < LINE_WIDTH_C);
    rd_in_range_s = {1'b0, rd_idx} < LINE_WIDTH_C;
  end

  // Front-bank read mux; the value is only used when the index is in range
  always_comb begin
    rd_word_s = 8'h00;
    if (wr_bank_r) begin
      rd_word_s = bank0_mem_r[rd_idx];
    end else begin
      rd_word_s = bank1_mem_r[rd_idx];
    end
  end

  // Per-bank write-port arbitration: renderer write first, pending clear
  // only if the renderer leaves that bank's port idle. A clear still in
  // flight when reset arrives is discarded.
  always_comb begin
    bank0_we_s    = 1'b0;
    bank0_widx_s  = 10'd0;
    bank0_wdata_s = 8'h00;
    bank1_we_s    = 1'b0;
    bank1_widx_s  = 10'd0;
    bank1_wdata_s = 8'h00;
    clr_fire_s    = clr_pend_r && !rst;

    if (wr_in_range_s) begin
      if (wr_bank_r == 1'b0) begin
        bank0_we_s    = 1'b1;
        bank0_widx_s  = linebuf_wridx;
        bank0_wdata_s = linebuf_wrdata;
      end else begin
        bank1_we_s    = 1'b1;
        bank1_widx_s  = linebuf_wridx;
        bank1_wdata_s = linebuf_wrdata;
      end
    end else begin
      bank0_we_s = 1'b0;
      bank1_we_s = 1'b0;
    end

    if (clr_fire_s) begin
      if (clr_bank_r == 1'b0) begin
        if (!bank0_we_s) begin
          bank0_we_s    = 1'b1;
          bank0_widx_s  = clr_idx_r;
          bank0_wdata_s = 8'h00;
        end else begin
          bank0_we_s = 1'b1;
        end
      end else begin
        if (!bank1_we_s) begin
          bank1_we_s    = 1'b1;
          bank1_widx_s  = clr_idx_r;
          bank1_wdata_s = 8'h00;
        end else begin
          bank1_we_s = 1'b1;
        end
      end
    end else begin
      clr_fire_s = 1'b0;
    end
  end

  // Bank storage: one write port per bank, contents are never reset
  always_ff @(posedge clk) begin
    if (bank0_we_s) begin
      bank0_mem_r[bank0_widx_s] <= bank0_wdata_s;
    end
    if (bank1_we_s) begin
      bank1_mem_r[bank1_widx_s] <= bank1_wdata_s;
    end
  end

  // Bank phase, clear pipeline and registered read port. Everything here
  // uses the pre-swap bank assignment, so a read on the swap cycle still
  // targets (and later clears) the bank that was front at that time.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_r  <= 1'b0;
      clr_pend_r <= 1'b0;
      clr_bank_r <= 1'b0;
      clr_idx_r  <= 10'd0;
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
    end else begin
      if (start_of_screen) begin
        wr_bank_r <= 1'b0;
      end else if (start_of_line) begin
        wr_bank_r <= ~wr_bank_r;
      end else begin
        wr_bank_r <= wr_bank_r;
      end

      rd_valid_r <= rd_en;
      if (rd_en && rd_in_range_s) begin
        rd_data_r <= rd_word_s;
      end else begin
        rd_data_r <= 8'h00;
      end

      clr_pend_r <= CLEAR_ON_READ && rd_en && rd_in_range_s;
      clr_bank_r <= ~wr_bank_r;
      clr_idx_r  <= rd_idx;
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;

endmodule
